// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  // Adder function select as seen by the datapath
  localparam logic ADDSUB_ADD = 1'b1;
  localparam logic ADDSUB_SUB = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDM   = 3'd1,
    LDQ   = 3'd2,
    EVAL  = 3'd3,
    ADD   = 3'd4,
    SUB   = 3'd5,
    SHIFT = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Every strobe the controller presents to the datapath, plus status
  typedef struct packed {
    logic load_a;
    logic load_q;
    logic load_m;
    logic clr_a;
    logic clr_ff;
    logic shft_a;
    logic shft_q;
    logic addsub;
    logic ld_cnt;
    logic decr;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore output decode: strobes depend on the state alone
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.addsub = ADDSUB_ADD;
    case (s)
      LDM: begin
        c.load_m = 1'b1;
        c.clr_a  = 1'b1;
        c.clr_ff = 1'b1;
        c.ld_cnt = 1'b1;
        c.busy   = 1'b1;
      end
      LDQ: begin
        c.load_q = 1'b1;
        c.busy   = 1'b1;
      end
      EVAL: c.busy = 1'b1;
      ADD: begin
        c.load_a = 1'b1;
        c.busy   = 1'b1;
      end
      SUB: begin
        c.load_a = 1'b1;
        c.addsub = ADDSUB_SUB;
        c.busy   = 1'b1;
      end
      SHIFT: begin
        c.shft_a = 1'b1;
        c.shft_q = 1'b1;
        c.decr   = 1'b1;
        c.busy   = 1'b1;
      end
      DONE: c.done = 1'b1;
      default: c.addsub = ADDSUB_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_controller.sv
// Sequencer for the 16-bit radix-2 Booth datapath: load M, load Q, then WIDTH evaluate/add-sub/shift rounds.
// Latency: 35..51 cycles from LDM entry to done; all outputs registered, no input-to-output paths.
// Backpressure: level handshake -- requester holds start until done, DONE is held while start stays high.
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic loadA,
  output logic loadQ,
  output logic loadM,
  output logic clrA,
  output logic clrQ,
  output logic clrff,
  output logic shftA,
  output logic shftQ,
  output logic addsub,
  output logic ldcnt,
  output logic decr,
  output logic busy,
  output logic done
);

  // The datapath counter is loaded with WIDTH, so it must be able to hold it
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
    $error("booth_controller: CNT_W too small for WIDTH");
  end

  state_t state;
  ctrl_t  ctrl;

  function automatic state_t next_state(input state_t s, input logic st,
                                        input logic z, input logic b0, input logic bm1);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:  n = st ? LDM : IDLE;
      LDM:   n = LDQ;
      LDQ:   n = EVAL;
      EVAL: begin
        if (z)                       n = DONE;
        else if ({b0, bm1} == 2'b01) n = ADD;
        else if ({b0, bm1} == 2'b10) n = SUB;
        else                         n = SHIFT;
      end
      ADD:   n = SHIFT;
      SUB:   n = SHIFT;
      SHIFT: n = EVAL;
      DONE:  n = st ? DONE : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // State register; outputs are registered alongside it from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctrl  <= ctrl_decode(IDLE);
    end else begin
      state <= next_state(state, start, eqz, q0, qm1);
      ctrl  <= ctrl_decode(next_state(state, start, eqz, q0, qm1));
    end
  end

  assign loadA  = ctrl.load_a;
  assign loadQ  = ctrl.load_q;
  assign loadM  = ctrl.load_m;
  assign clrA   = ctrl.clr_a;
  assign clrQ   = 1'b0;          // Q is always fully overwritten in LDQ
  assign clrff  = ctrl.clr_ff;
  assign shftA  = ctrl.shft_a;
  assign shftQ  = ctrl.shft_q;
  assign addsub = ctrl.addsub;
  assign ldcnt  = ctrl.ld_cnt;
  assign decr   = ctrl.decr;
  assign busy   = ctrl.busy;
  assign done   = ctrl.done;

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller with a behavioural Booth datapath attached.
// Latency: checks product, add/sub/shift/decr counts and LDM-to-done cycle count per operation.
// Backpressure: driver holds start until done; scoreboard queue decouples stimulus from checking.
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic q0, qm1, eqz;
  logic loadA, loadQ, loadM, clrA, clrQ, clrff, shftA, shftQ, addsub, ldcnt, decr, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_controller #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .q0(q0), .qm1(qm1), .eqz(eqz),
    .loadA(loadA), .loadQ(loadQ), .loadM(loadM),
    .clrA(clrA), .clrQ(clrQ), .clrff(clrff),
    .shftA(shftA), .shftQ(shftQ), .addsub(addsub),
    .ldcnt(ldcnt), .decr(decr), .busy(busy), .done(done)
  );

  // behavioural datapath
  logic [15:0] mcand, mplier, data_in;
  logic [15:0] dp_a, dp_q, dp_m;
  logic        dp_qm1;
  logic [4:0]  dp_cnt;

  assign data_in = loadM ? mcand : mplier;
  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;
  assign eqz = (dp_cnt == 5'd0);

  // datapath registers react to the controller strobes
  always @(posedge clk) begin
    if (loadM) dp_m <= data_in;
    if (clrA) dp_a <= 16'h0;
    if (clrff) dp_qm1 <= 1'b0;
    if (ldcnt) dp_cnt <= 5'd16;
    if (loadQ) dp_q <= data_in;
    if (loadA) dp_a <= addsub ? dp_a + dp_m : dp_a - dp_m;
    if (shftA && shftQ) {dp_a, dp_q, dp_qm1} <= {dp_a[15], dp_a, dp_q};
    if (decr) dp_cnt <= dp_cnt - 5'd1;
  end

  logic [12:0] outs;
  assign outs = {loadA, loadQ, loadM, clrA, clrQ, clrff, shftA, shftQ, addsub, ldcnt, decr, busy, done};
  localparam logic [12:0] IDLE_VEC = 13'h0010;  // only addsub high

  typedef struct {
    logic [31:0] prod;
    int adds;
    int subs;
    int shf;
    int cyc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // monitor: counts strobes per operation and scores each rising done
  initial begin
    int n_add, n_sub, n_dec, n_shf, cyc;
    logic done_q;
    exp_t e;
    n_add = 0; n_sub = 0; n_dec = 0; n_shf = 0; cyc = 0; done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_q = 1'b0;
      end else begin
        if (loadM) begin
          n_add = 0; n_sub = 0; n_dec = 0; n_shf = 0; cyc = 0;
        end else begin
          cyc++;
        end
        if (loadA && addsub)  n_add++;
        if (loadA && !addsub) n_sub++;
        if (decr)             n_dec++;
        if (shftA && shftQ)   n_shf++;
        if (done && !done_q) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected_done: got done with empty queue, required none");
          end else begin
            e = sb.pop_front();
            check("product", {dp_a, dp_q}, e.prod);
            check("add_visits", 32'(n_add), 32'(e.adds));
            check("sub_visits", 32'(n_sub), 32'(e.subs));
            check("shift_pulses", 32'(n_shf), 32'(e.shf));
            check("decr_pulses", 32'(n_dec), 32'(e.shf));
            check("ldm_to_done_cycles", 32'(cyc), 32'(e.cyc));
          end
        end
        done_q = done;
      end
    end
  end

  task automatic push(input logic [31:0] p, input int a, input int s, input int c);
    exp_t e;
    e.prod = p; e.adds = a; e.subs = s; e.shf = 16; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                        input logic [31:0] p, input int a, input int s, input int c);
    @(negedge clk);
    mcand = mc; mplier = mp;
    push(p, a, s, c);
    start = 1'b1;
    wait_done("run_op");
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nsh;
    rst_n = 1'b0; start = 1'b1; mcand = 16'd3; mplier = 16'd5;
    // reset held with start high: stays IDLE
    repeat (3) begin
      @(negedge clk);
      check("reset_idle_outputs", 32'(outs), 32'(IDLE_VEC));
    end
    // start already high at release: accepted on the first rising edge (3 x 5)
    push(32'h0000_000F, 2, 2, 39);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_ldm", 32'(loadM), 32'd1);
    wait_done("first");
    start = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'(outs), 32'(IDLE_VEC));

    run_op(16'hFFF9, 16'h0006, 32'hFFFF_FFD6, 1, 1, 37);
    run_op(16'h1234, 16'h0000, 32'h0000_0000, 0, 0, 35);
    run_op(16'h0003, 16'h5555, 32'h0000_FFFF, 8, 8, 51);
    run_op(16'h7FFF, 16'hFFFF, 32'hFFFF_8001, 0, 1, 36);

    // start held after done keeps DONE; drop -> IDLE; reassert -> LDM
    @(negedge clk);
    mcand = 16'd3; mplier = 16'd5;
    push(32'h0000_000F, 2, 2, 39);
    start = 1'b1;
    wait_done("hold");
    repeat (4) @(negedge clk);
    check("done_held", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("drop_start_idle", 32'(outs), 32'(IDLE_VEC));
    push(32'h0000_000F, 2, 2, 39);
    start = 1'b1;
    @(negedge clk);
    check("restart_ldm", 32'(loadM), 32'd1);
    wait_done("restart");
    start = 1'b0;
    @(negedge clk);

    // reset pulsed during the 8th SHIFT
    mcand = 16'd3; mplier = 16'd5;
    start = 1'b1;
    nsh = 0;
    for (int i = 0; i < 200 && nsh < 8; i++) begin
      @(negedge clk);
      if (shftA) nsh++;
    end
    check("mid_reset_reached_shift8", 32'(nsh), 32'd8);
    rst_n = 1'b0;
    #1;
    check("mid_reset_immediate_idle", 32'(outs), 32'(IDLE_VEC));
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset_held_idle", 32'(outs), 32'(IDLE_VEC));
    rst_n = 1'b1;
    run_op(16'd3, 16'd5, 32'h0000_000F, 2, 2, 39);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
